// File: rtl/serial_adder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : serial_adder_if
// Purpose  : Request/result bundle between a datapath master and the
//            bit-serial adder/subtractor.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             V;

  modport master (
    output start, sub, A, B, Ci,
    input  busy, done, S, Co, V
  );

  modport slave (
    input  start, sub, A, B, Ci,
    output busy, done, S, Co, V
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder/subtractor. Operands are captured on
//            start, fed LSB-first through a single full-adder cell with a
//            carry flop, and the result is presented with a done pulse.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// Module   : full_adder
// Purpose  : One-bit full-adder cell.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module full_adder (
  input  wire logic A,
  input  wire logic B,
  input  wire logic Ci,
  output logic      S,
  output logic      Co
);
  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_v;

  logic             w_sum;
  logic             w_co;
  logic [WIDTH-1:0] w_s_next;

  full_adder u_fa (
    .A  (r_a_sr[0]),
    .B  (r_b_sr[0]),
    .Ci (r_carry),
    .S  (w_sum),
    .Co (w_co)
  );

  // The working sum fills from the MSB so after WIDTH shifts bit 0 is at LSB.
  assign w_s_next = {w_sum, r_s_sr[WIDTH-1:1]};

  // Sequencer: capture, shift one bit per clock, publish result with done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a_sr  <= bus.A;
            // Subtraction is A + ~B + 1: invert B and force carry-in high.
            r_b_sr  <= bus.sub ? ~bus.B : bus.B;
            r_carry <= bus.sub ? 1'b1 : bus.Ci;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_s_sr  <= w_s_next;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            // r_carry here is the carry into the MSB; overflow is that
            // carry differing from the carry out of the MSB.
            r_s     <= w_s_next;
            r_co    <= w_co;
            r_v     <= r_carry ^ w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.S    = r_s;
  assign bus.Co   = r_co;
  assign bus.V    = r_v;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_serial_adder
// Purpose  : Directed self-checking bench for serial_adder (WIDTH = 8).
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  logic [WIDTH-1:0] exp_prev_s;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // One operation: present on a negedge, capture on the next posedge, then
  // follow busy/done and check the result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb,
                        input logic [7:0] es, input logic eco, input logic ev);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.Ci = ci; bus.sub = sb;
    @(negedge clk);
    bus.start = 1'b0;
    // Scramble operands after capture; they must have no effect.
    bus.A = ~a; bus.B = ~b; bus.Ci = ~ci; bus.sub = ~sb;
    lat = 0;
    while (!bus.done && lat < 20) begin
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_hold"}, {24'd0, bus.S}, {24'd0, exp_prev_s});
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, WIDTH);
    chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_S"}, {24'd0, bus.S}, {24'd0, es});
    chk({tag, "_Co"}, {31'd0, bus.Co}, {31'd0, eco});
    chk({tag, "_V"}, {31'd0, bus.V}, {31'd0, ev});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_S_held"}, {24'd0, bus.S}, {24'd0, es});
    exp_prev_s = es;
  endtask

  initial begin
    int gap;
    int t;
    n_total = 0;
    n_bad = 0;
    exp_prev_s = '0;
    rst_n = 1'b0;
    bus.start = 1'b1; bus.sub = 1'b0; bus.A = 8'h3C; bus.B = 8'h0F; bus.Ci = 1'b0;

    // Reset held with start asserted: nothing begins.
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_S", {24'd0, bus.S}, 32'd0);
    chk("rst_Co", {31'd0, bus.Co}, 32'd0);
    chk("rst_V", {31'd0, bus.V}, 32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", {31'd0, bus.busy}, 32'd0);

    run_op("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Back-to-back with start held high; A briefly AA mid-shift.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'h01; bus.B = 8'h02; bus.Ci = 1'b0; bus.sub = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    bus.A = 8'hAA;
    repeat (2) @(negedge clk);
    bus.A = 8'h01;
    t = 0;
    while (!bus.done && t < 20) begin @(negedge clk); t++; end
    chk("b2b_first_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_first_S", {24'd0, bus.S}, 32'h03);
    gap = 0;
    @(negedge clk); gap++;
    while (!bus.done && gap < 20) begin @(negedge clk); gap++; end
    bus.start = 1'b0;
    chk("b2b_second_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_second_S", {24'd0, bus.S}, 32'h03);
    chk("b2b_gap_bound", {31'd0, (gap >= WIDTH + 1 && gap <= WIDTH + 2)}, 32'd1);
    @(negedge clk);
    exp_prev_s = 8'h03;

    // Reset in the middle of an operation.
    bus.start = 1'b1; bus.A = 8'h10; bus.B = 8'h20; bus.Ci = 1'b0; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_S", {24'd0, bus.S}, 32'd0);
    rst_n = 1'b1;
    t = 0;
    repeat (WIDTH + 2) begin
      @(negedge clk);
      if (bus.done) t++;
    end
    chk("midrst_no_done", t, 0);
    exp_prev_s = '0;
    run_op("after_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
